// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and defaults for the SRAM memory responder.
//   state_e         : responder FSM states (IDLE, LOW, HIGH, DONE)
//   op_e            : latched access type (OP_RD, OP_WR)
//   WAIT_CYCLES_DEF : default cycles per half-word phase
//   ADDR_BASE_DEF   : default byte address mapped to SRAM word 0
//   SRAM_DW         : SRAM data bus width
//   cnt_width()     : phase counter width, never less than one bit
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int WAIT_CYCLES_DEF = 3;
    localparam int ADDR_BASE_DEF   = 1024;
    localparam int SRAM_DW         = 16;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// -----------------------------------------------------------------------------
// sram_phase_counter
// Counts the cycles of one half-word SRAM phase.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   clear  : force the count back to 0 (wins over enable)
//   enable : advance the count by one
//   last   : count equals WAIT_CYCLES-1 (final cycle of the phase)
// -----------------------------------------------------------------------------
module sram_phase_counter
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = cnt_width(WAIT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_responder.sv
// -----------------------------------------------------------------------------
// sram_mem_responder
// Responder side of the pipeline memory handshake. A 32-bit load/store from the
// MEM stage is carried out as two 16-bit SRAM cycles (low half, then high
// half), each WAIT_CYCLES long. `ready` is low while the access runs, which
// freezes the pipeline, and high for one completion cycle at the end.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   rd_en, wr_en      : load / store request (both high = store)
//   address           : byte address, ADDR_BASE maps to SRAM word 0
//   write_data        : store data
//   read_data         : load result, held until the next load completes
//   ready             : 0 = stall, 1 = complete or nothing pending
//   sram_addr         : half-word address {word, half}
//   sram_dq_out/_in   : pad data out / in, sram_dq_oe drives the pad
//   sram_we_n/oe_n/ce_n : active-low SRAM strobes
//
// Build option: define SRAM_LAST_READ_HIT_EN to keep the word address of the
// last completed load; a load to that same word then completes with no stall
// and no SRAM cycle. Stores to that word invalidate it.
// -----------------------------------------------------------------------------
module sram_mem_responder
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int ADDR_BASE   = ADDR_BASE_DEF,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] read_data_q, read_data_d;

    logic        req;
    logic        hit;
    logic        cnt_clear;
    logic        cnt_en;
    logic        cnt_last;
    logic        active;
    logic        half;

    // Word index relative to ADDR_BASE; wraps modulo 2^32.
    logic [31:0] addr_off;
    logic [29:0] word;
    logic        unused_addr_bits;

    assign addr_off = address - 32'(ADDR_BASE);
    assign word     = addr_off[31:2];
    assign req      = rd_en | wr_en;

    // Byte offset and word bits above the SRAM range are dropped on purpose.
    assign unused_addr_bits = ^{addr_off[1:0], word[29:SRAM_AW-1]};

    // -------------------------------------------------------------------------
    // Last-read tag
    // -------------------------------------------------------------------------
`ifdef SRAM_LAST_READ_HIT_EN
    logic        valid_q, valid_d;
    logic [29:0] tag_q, tag_d;

    assign hit = valid_q && rd_en && !wr_en && (word == tag_q);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        // A store into the cached word makes the tag stale as soon as it starts.
        if (state_q == IDLE && wr_en && valid_q && (word == tag_q)) begin
            valid_d = 1'b0;
        end
        if (state_q == HIGH && cnt_last && op_q == OP_RD) begin
            tag_d   = word;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Phase counter: restarts at every phase boundary and while idle.
    // -------------------------------------------------------------------------
    assign cnt_clear = (state_q == IDLE) || cnt_last;
    assign cnt_en    = (state_q == LOW) || (state_q == HIGH);

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .last   (cnt_last)
    );

    // -------------------------------------------------------------------------
    // FSM and read capture
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        read_data_d = read_data_q;
        ready       = 1'b0;
        case (state_q)
            IDLE: begin
                // Combinational so the stall starts in the request cycle.
                ready = !req || hit;
                if (req && !hit) begin
                    state_d = LOW;
                    op_d    = wr_en ? OP_WR : OP_RD;
                end
            end
            LOW: begin
                if (cnt_last) begin
                    state_d = HIGH;
                    if (op_q == OP_RD) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end
            end
            HIGH: begin
                if (cnt_last) begin
                    state_d = DONE;
                    if (op_q == OP_RD) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end
            end
            DONE: begin
                // The request is still visible here; return to IDLE without
                // acting on it so it is not replayed.
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

    // -------------------------------------------------------------------------
    // Pad decode, purely from state so every strobe is idle while in reset.
    // -------------------------------------------------------------------------
    assign active = (state_q == LOW) || (state_q == HIGH);
    assign half   = (state_q == HIGH);

    always_comb begin
        sram_ce_n   = !active;
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        if (active) begin
            sram_addr = {word[SRAM_AW-2:0], half};
            if (op_q == OP_WR) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = half ? write_data[31:16] : write_data[15:0];
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_responder
// Scoreboard bench: each access pushes its expected read_data when driven and
// pops it when ready signals completion. A small half-word SRAM model sits on
// the pads. Hit-path tests are compiled in with SRAM_LAST_READ_HIT_EN.
// -----------------------------------------------------------------------------
module tb_sram_mem_responder;

    localparam int W         = 3;
    localparam int ADDR_BASE = 1024;
    localparam int SRAM_AW   = 18;
`ifdef SRAM_LAST_READ_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;
    logic               sram_ce_n;

    sram_mem_responder #(
        .WAIT_CYCLES (W),
        .ADDR_BASE   (ADDR_BASE),
        .SRAM_AW     (SRAM_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ce_n   (sram_ce_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Half-word SRAM pad model (small window is enough for these addresses).
    logic [15:0] sram_mem [0:63];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    // Scoreboard and reference state
    logic [31:0] sb_q [$];
    logic [31:0] model_words [int];
    logic [31:0] last_rd;
    bit          tag_valid;
    logic [29:0] tag_word;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    function automatic logic [29:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'(ADDR_BASE);
        return off[31:2];
    endfunction

    function automatic logic [31:0] model_read(input logic [29:0] wd);
        if (model_words.exists(int'(wd))) return model_words[int'(wd)];
        return 32'h0;
    endfunction

    // Count edges until ready rises; an expired bound is reported by the
    // caller's stall comparison.
    task automatic wait_ready(input logic [29:0] wd, input bit is_wr,
                              input logic [31:0] data, output int n);
        logic [SRAM_AW-1:0] a0;
        a0 = {wd[SRAM_AW-2:0], 1'b0};
        n  = 0;
        while (!ready && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                check("addr_low", 32'(sram_addr), 32'(a0));
                if (is_wr) check("dq_low", 32'(sram_dq_out), 32'(data[15:0]));
            end
            if (n == W + 1) begin
                check("addr_high", 32'(sram_addr), 32'(a0 | 1'b1));
                if (is_wr) check("dq_high", 32'(sram_dq_out), 32'(data[31:16]));
            end
        end
    endtask

    task automatic update_model(input bit rd, input bit wr, input logic [29:0] wd,
                                input logic [31:0] data, input logic [31:0] exp);
        if (wr) begin
            model_words[int'(wd)] = data;
            if (tag_word == wd) tag_valid = 1'b0;
        end else if (rd) begin
            last_rd   = exp;
            tag_word  = wd;
            tag_valid = 1'b1;
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data);
        logic [29:0] wd;
        logic [31:0] exp;
        bit          hit;
        int          n;
        wd  = word_of(addr);
        hit = HIT_EN && rd && !wr && tag_valid && (tag_word == wd);
        exp = wr ? last_rd : model_read(wd);
        sb_q.push_back(exp);

        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        #1;
        if (hit) begin
            check("hit_ready", 32'(ready), 32'd1);
        end else begin
            check("req_stall", 32'(ready), 32'd0);
            wait_ready(wd, wr, data, n);
            check("latency", 32'(n), 32'(2 * W + 1));
        end
        check("read_data", read_data, sb_q.pop_front());
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_ce_n", 32'(sram_ce_n), 32'd1);
        update_model(rd, wr, wd, data, exp);
    endtask

    initial begin
        int n;
        logic [31:0] exp;
        n_cmp = 0; n_bad = 0;
        last_rd = 32'h0; tag_valid = 1'b0; tag_word = '0;
        for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0;
        rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; write_data = 32'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_strobes", {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h6);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        rst = 1'b1;

        // Store, then load back, then an unrelated store
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        check("mem0", 32'(sram_mem[0]), 32'h0000BEEF);
        check("mem1", 32'(sram_mem[1]), 32'h0000DEAD);
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        access(1'b0, 1'b1, 32'd1028, 32'h11112222);
        access(1'b0, 1'b1, 32'd1032, 32'h12345678);
        check("mem4", 32'(sram_mem[4]), 32'h00005678);
        check("mem5", 32'(sram_mem[5]), 32'h00001234);

        // Both enables: behaves as a store
        access(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5);
        check("both_mem0", 32'(sram_mem[0]), 32'h0000A5A5);
        access(1'b1, 1'b0, 32'd1032, 32'h0);

        // Reset in the middle of a load, request held throughout
        exp = model_read(word_of(32'd1024));
        sb_q.push_back(exp);
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1024;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tag_valid = 1'b0;
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_read_data", read_data, 32'h0);
        check("mid_rst_ce_n", 32'(sram_ce_n), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        wait_ready(word_of(32'd1024), 1'b0, 32'h0, n);
        check("restart_latency", 32'(n), 32'(2 * W + 1));
        check("restart_read_data", read_data, sb_q.pop_front());
        rd_en = 1'b0;
        @(posedge clk); #1;
        check("restart_idle", 32'(ready), 32'd1);
        update_model(1'b1, 1'b0, word_of(32'd1024), 32'h0, exp);

        // Repeat load of the same word; a hit when the tag feature is built in
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'd1024, 32'h0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1, "timeout");
    end

endmodule
